// File: rtl/tensor_reshape_copy_if.sv
// Memory handle bundle shared by the tensor engines.
//   region_begin : base word address of the tensor region (memory side)
//   ptr          : word address of the current request
//   r_en / w_en  : read / write request, held until done
//   avail        : request valid, mirrors r_en | w_en
//   data_store   : write data
//   data_load    : read data, valid in the done cycle
//   done         : one-cycle request completion
interface tensor_reshape_copy_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] region_begin;
  logic [DATA_W-1:0] ptr;
  logic [DATA_W-1:0] data_store;
  logic [DATA_W-1:0] data_load;
  logic              r_en;
  logic              w_en;
  logic              avail;
  logic              done;

  modport master (
    input  region_begin, data_load, done,
    output ptr, data_store, r_en, w_en, avail
  );

  modport slave (
    output region_begin, data_load, done,
    input  ptr, data_store, r_en, w_en, avail
  );
endinterface

// File: rtl/tensor_reshape_copy.sv
// Tensor reshape engine: reads the source header, writes a destination
// header (flatten / reshape / copy), then streams every data word across.
//   clk, rst_l    : clock, asynchronous active-low reset
//   src           : source tensor handle (reads only)
//   shp           : target-shape handle, header read in RESHAPE only
//   dst           : destination tensor handle (writes only)
//   i_go          : level start, sampled in IDLE
//   i_mode        : 0 FLATTEN, 1 RESHAPE, 2 COPY, 3 reserved (error)
//   o_done        : operation finished, held until i_go drops
//   o_err         : fault flag, valid with o_done
//   o_elem_count  : product of source dims
module tensor_reshape_copy #(
  parameter int unsigned MAX_DIMS = 4,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_l,
  tensor_reshape_copy_if.master src,
  tensor_reshape_copy_if.master shp,
  tensor_reshape_copy_if.master dst,
  input  logic                  i_go,
  input  logic [1:0]            i_mode,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_W-1:0]     o_elem_count
);

  // Index covers 0..MAX_DIMS (header word count); regfile padded to 2**IDX_W
  // so the index selects it without width adaption.
  localparam int unsigned IDX_W  = $clog2(MAX_DIMS + 2);
  localparam int unsigned DIM_N  = 1 << IDX_W;
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [1:0] MODE_FLATTEN = 2'd0;
  localparam logic [1:0] MODE_RESHAPE = 2'd1;
  localparam logic [1:0] MODE_RSV     = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_SRC_NDIM, S_SRC_DIM, S_SHP_NDIM, S_SHP_DIM,
    S_DST_HDR, S_COPY_R, S_COPY_W, S_DONE
  } state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_ndims;
  logic [DATA_W-1:0]   r_dims [DIM_N];
  logic [DATA_W-1:0]   r_elem_count;
  logic [DATA_W-1:0]   r_prod;
  logic [DATA_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_word;
  logic                r_done;
  logic                r_err;

  logic                r_src_ren;
  logic [DATA_W-1:0]   r_src_ptr;
  logic                r_shp_ren;
  logic [DATA_W-1:0]   r_shp_ptr;
  logic                r_dst_wen;
  logic [DATA_W-1:0]   r_dst_ptr;
  logic [DATA_W-1:0]   r_dst_data;

  logic [PROD_W-1:0]   w_src_prod;
  logic [PROD_W-1:0]   w_shp_prod;
  logic [IDX_W-1:0]    w_dim_idx;
  logic [DATA_W-1:0]   w_hdr_word;
  logic                w_unused_ok;

  // Header ndims must lie in 1..MAX_DIMS.
  function automatic logic ndims_ok(input logic [DATA_W-1:0] n);
    return (n != '0) && (n <= DATA_W'(MAX_DIMS));
  endfunction

  // Full-width products so overflow past DATA_W bits is visible.
  assign w_src_prod = PROD_W'(r_elem_count) * PROD_W'(src.data_load);
  assign w_shp_prod = PROD_W'(r_prod) * PROD_W'(shp.data_load);
  assign w_dim_idx  = r_idx - IDX_W'(1);

  // Destination header word for the current index.
  always_comb begin
    w_hdr_word = DATA_W'(r_ndims);
    if (r_idx != '0) begin
      w_hdr_word = (r_mode == MODE_FLATTEN) ? r_elem_count : r_dims[w_dim_idx];
    end
  end

  // Handle drive from registers.
  assign src.ptr        = r_src_ptr;
  assign src.r_en       = r_src_ren;
  assign src.w_en       = 1'b0;
  assign src.avail      = r_src_ren;
  assign src.data_store = '0;
  assign shp.ptr        = r_shp_ptr;
  assign shp.r_en       = r_shp_ren;
  assign shp.w_en       = 1'b0;
  assign shp.avail      = r_shp_ren;
  assign shp.data_store = '0;
  assign dst.ptr        = r_dst_ptr;
  assign dst.r_en       = 1'b0;
  assign dst.w_en       = r_dst_wen;
  assign dst.avail      = r_dst_wen;
  assign dst.data_store = r_dst_data;
  assign w_unused_ok    = ^dst.data_load;

  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_elem_count = r_elem_count;

  // Sequencer: each state issues one request when idle, then consumes it on done.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state      <= S_IDLE;
      r_mode       <= MODE_FLATTEN;
      r_idx        <= '0;
      r_ndims      <= '0;
      for (int i = 0; i < DIM_N; i++) r_dims[i] <= '0;
      r_elem_count <= '0;
      r_prod       <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_src_ren    <= 1'b0;
      r_src_ptr    <= '0;
      r_shp_ren    <= 1'b0;
      r_shp_ptr    <= '0;
      r_dst_wen    <= 1'b0;
      r_dst_ptr    <= '0;
      r_dst_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_go) begin
            r_mode       <= i_mode;
            r_src_ptr    <= src.region_begin;
            r_shp_ptr    <= shp.region_begin;
            r_dst_ptr    <= dst.region_begin;
            r_elem_count <= '0;
            r_idx        <= '0;
            if (i_mode == MODE_RSV) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_SRC_NDIM;
            end
          end
        end

        S_SRC_NDIM: begin
          if (!r_src_ren) begin
            r_src_ren <= 1'b1;
          end else if (src.done) begin
            r_src_ren <= 1'b0;
            r_src_ptr <= r_src_ptr + DATA_W'(1);
            if (!ndims_ok(src.data_load)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_ndims      <= IDX_W'(src.data_load);
              r_elem_count <= DATA_W'(1);
              r_idx        <= '0;
              r_state      <= S_SRC_DIM;
            end
          end
        end

        S_SRC_DIM: begin
          if (!r_src_ren) begin
            r_src_ren <= 1'b1;
          end else if (src.done) begin
            r_src_ren <= 1'b0;
            r_src_ptr <= r_src_ptr + DATA_W'(1);
            if (w_src_prod[PROD_W-1:DATA_W] != '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_elem_count  <= w_src_prod[DATA_W-1:0];
              r_dims[r_idx] <= src.data_load;
              if (r_idx == r_ndims - IDX_W'(1)) begin
                r_idx <= '0;
                if (r_mode == MODE_RESHAPE) begin
                  r_state <= S_SHP_NDIM;
                end else begin
                  // Flattened header is a single dim holding the element count.
                  if (r_mode == MODE_FLATTEN) r_ndims <= IDX_W'(1);
                  r_state <= S_DST_HDR;
                end
              end else begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end
          end
        end

        S_SHP_NDIM: begin
          if (!r_shp_ren) begin
            r_shp_ren <= 1'b1;
          end else if (shp.done) begin
            r_shp_ren <= 1'b0;
            r_shp_ptr <= r_shp_ptr + DATA_W'(1);
            if (!ndims_ok(shp.data_load)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_ndims <= IDX_W'(shp.data_load);
              r_prod  <= DATA_W'(1);
              r_idx   <= '0;
              r_state <= S_SHP_DIM;
            end
          end
        end

        // Target dims overwrite the source dims; the source shape is no longer needed.
        S_SHP_DIM: begin
          if (!r_shp_ren) begin
            r_shp_ren <= 1'b1;
          end else if (shp.done) begin
            r_shp_ren     <= 1'b0;
            r_shp_ptr     <= r_shp_ptr + DATA_W'(1);
            r_dims[r_idx] <= shp.data_load;
            r_prod        <= w_shp_prod[DATA_W-1:0];
            if (w_shp_prod[PROD_W-1:DATA_W] != '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (r_idx == r_ndims - IDX_W'(1)) begin
              r_idx <= '0;
              if (w_shp_prod[DATA_W-1:0] != r_elem_count) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
              end else begin
                r_state <= S_DST_HDR;
              end
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

        S_DST_HDR: begin
          if (!r_dst_wen) begin
            r_dst_wen  <= 1'b1;
            r_dst_data <= w_hdr_word;
          end else if (dst.done) begin
            r_dst_wen <= 1'b0;
            r_dst_ptr <= r_dst_ptr + DATA_W'(1);
            if (r_idx == r_ndims) begin
              r_cnt <= '0;
              if (r_elem_count == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_COPY_R;
              end
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

        S_COPY_R: begin
          if (!r_src_ren) begin
            if (r_cnt == r_elem_count) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_src_ren <= 1'b1;
            end
          end else if (src.done) begin
            r_src_ren <= 1'b0;
            r_src_ptr <= r_src_ptr + DATA_W'(1);
            r_word    <= src.data_load;
            r_state   <= S_COPY_W;
          end
        end

        S_COPY_W: begin
          if (!r_dst_wen) begin
            r_dst_wen  <= 1'b1;
            r_dst_data <= r_word;
          end else if (dst.done) begin
            r_dst_wen <= 1'b0;
            r_dst_ptr <= r_dst_ptr + DATA_W'(1);
            r_cnt     <= r_cnt + DATA_W'(1);
            // Finishing here puts done one cycle after the last write completes.
            if ((r_cnt + DATA_W'(1)) == r_elem_count) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_COPY_R;
            end
          end
        end

        S_DONE: begin
          if (!i_go) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_reshape_copy.sv
module tb_tensor_reshape_copy;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_DIMS = 4;

  logic              clk = 1'b0;
  logic              rst_l = 1'b0;
  logic              go = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] elem;

  always #5 clk = ~clk;

  tensor_reshape_copy_if #(.DATA_W(DATA_W)) src_if ();
  tensor_reshape_copy_if #(.DATA_W(DATA_W)) shp_if ();
  tensor_reshape_copy_if #(.DATA_W(DATA_W)) dst_if ();

  tensor_reshape_copy #(.MAX_DIMS(MAX_DIMS), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .src          (src_if),
    .shp          (shp_if),
    .dst          (dst_if),
    .i_go         (go),
    .i_mode       (mode),
    .o_done       (done),
    .o_err        (err),
    .o_elem_count (elem)
  );

  // Memory: src and shp read src_mem, dst writes dst_mem. Handle 0=src, 1=shp, 2=dst.
  logic [31:0] src_mem [256];
  logic [31:0] dst_mem [256];
  logic        req [4], wr [4], av [4], hdone [4], busy [4];
  logic [31:0] hptr [4], hstore [4], hload [4], cptr [4], cstore [4];
  int unsigned cnt [4], pre [4];
  int unsigned acc [4] = '{0, 0, 0, 0};
  int          viol = 0;
  bit          stall_en = 1'b0;
  bit          clr_req = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  assign req[0] = src_if.r_en | src_if.w_en;  assign wr[0] = src_if.w_en;
  assign req[1] = shp_if.r_en | shp_if.w_en;  assign wr[1] = shp_if.w_en;
  assign req[2] = dst_if.r_en | dst_if.w_en;  assign wr[2] = dst_if.w_en;
  assign req[3] = 1'b0;  assign wr[3] = 1'b0;  assign av[3] = 1'b0;
  assign av[0] = src_if.avail;  assign av[1] = shp_if.avail;  assign av[2] = dst_if.avail;
  assign hptr[0] = src_if.ptr;  assign hptr[1] = shp_if.ptr;  assign hptr[2] = dst_if.ptr;
  assign hptr[3] = 32'd0;
  assign hstore[0] = src_if.data_store;  assign hstore[1] = shp_if.data_store;
  assign hstore[2] = dst_if.data_store;  assign hstore[3] = 32'd0;
  assign src_if.done = hdone[0];  assign src_if.data_load = hload[0];
  assign shp_if.done = hdone[1];  assign shp_if.data_load = hload[1];
  assign dst_if.done = hdone[2];  assign dst_if.data_load = hload[2];
  assign src_if.region_begin = 32'd0;
  assign shp_if.region_begin = 32'd64;
  assign dst_if.region_begin = 32'd128;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int h = 0; h < 4; h++) begin
        hdone[2'(h)] <= 1'b0;
        busy[2'(h)]  <= 1'b0;
        pre[2'(h)]   <= 0;
      end
    end else begin
      if (clr_req) for (int i = 0; i < 256; i++) dst_mem[8'(i)] <= 32'hDEAD_BEEF;
      for (int h = 0; h < 3; h++) begin
        if (av[2'(h)] !== req[2'(h)]) viol <= viol + 1;
        if (busy[2'(h)] && (hptr[2'(h)] !== cptr[2'(h)] || hstore[2'(h)] !== cstore[2'(h)]))
          viol <= viol + 1;
        if (req[2'(h)] && (wr[2'(h)] != (h == 2))) viol <= viol + 1;
        if (hdone[2'(h)]) begin
          hdone[2'(h)] <= 1'b0;
        end else if (req[2'(h)]) begin
          if ((!busy[2'(h)] && pre[2'(h)] == 0) || (busy[2'(h)] && cnt[2'(h)] == 0)) begin
            hdone[2'(h)] <= 1'b1;
            busy[2'(h)]  <= 1'b0;
            acc[2'(h)]   <= acc[2'(h)] + 1;
            if (h == 2) begin
              hload[2'(h)] <= dst_mem[hptr[2'(h)][7:0]];
              dst_mem[hptr[2'(h)][7:0]] <= hstore[2'(h)];
            end else begin
              hload[2'(h)] <= src_mem[hptr[2'(h)][7:0]];
            end
            pre[2'(h)] <= stall_en ? $urandom_range(0, 5) : 0;
          end else if (!busy[2'(h)]) begin
            busy[2'(h)]   <= 1'b1;
            cnt[2'(h)]    <= pre[2'(h)] - 1;
            cptr[2'(h)]   <= hptr[2'(h)];
            cstore[2'(h)] <= hstore[2'(h)];
          end else begin
            cnt[2'(h)] <= cnt[2'(h)] - 1;
          end
        end
      end
    end
  end

  task automatic load_src(input int base, input logic [31:0] q[$]);
    foreach (q[i]) src_mem[8'(base + i)] = q[i];
  endtask

  task automatic clear_dst();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  // Start an operation and wait (bounded) for done; optionally flip mode mid-run.
  task automatic run_op(input logic [1:0] m, input int flip_at);
    int cycles = 0;
    mode = m;
    go = 1'b1;
    while (!done && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (cycles == flip_at) mode = 2'd2;
    end
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL run_op_timeout: done=%0b required 1", done); end
  endtask

  task automatic finish_op();
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
    n_tests++; if (elem !== 32'd0) begin n_fail++; $display("FAIL reset_elem: got %0d want 0", elem); end
    n_tests++;
    if ({src_if.r_en, src_if.avail, shp_if.r_en, dst_if.w_en, dst_if.avail} !== 5'b0 || src_if.ptr !== 32'd0 ||
        dst_if.ptr !== 32'd0 || dst_if.data_store !== 32'd0) begin
      n_fail++; $display("FAIL reset_handles: src_ptr=%h dst_ptr=%h src_ren=%0b dst_wen=%0b want all 0",
                          src_if.ptr, dst_if.ptr, src_if.r_en, dst_if.w_en);
    end
    rst_l = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (done !== 1'b0 || src_if.r_en !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet: done=%0b src_ren=%0b want 0 0", done, src_if.r_en); end
  endtask

  task automatic test_flatten();
    logic [31:0] q[$], exp[$];
    int unsigned a0 = acc[2'd2];
    int v0 = viol;
    q = '{3, 2, 3, 4};
    exp = '{1, 24};
    for (int i = 0; i < 24; i++) begin q.push_back(32'hA000 + i); exp.push_back(32'hA000 + i); end
    load_src(0, q);
    clear_dst();
    run_op(2'd0, 0);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL flatten_err: got %0b want 0", err); end
    n_tests++; if (elem !== 32'd24) begin n_fail++; $display("FAIL flatten_elem: got %0d want 24", elem); end
    foreach (exp[i]) begin
      n_tests++;
      if (dst_mem[8'(128 + i)] !== exp[i]) begin
        n_fail++; $display("FAIL flatten_word%0d: got %h want %h", i, dst_mem[8'(128 + i)], exp[i]); end
    end
    n_tests++; if (dst_mem[8'd154] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL flatten_overrun: got %h want deadbeef", dst_mem[8'd154]); end
    n_tests++; if (acc[2'd2] - a0 !== 26) begin
      n_fail++; $display("FAIL flatten_dst_writes: got %0d want 26", acc[2'd2] - a0); end
    n_tests++; if (viol !== v0) begin n_fail++; $display("FAIL flatten_protocol: got %0d want 0", viol - v0); end
    finish_op();
  endtask

  task automatic test_reshape();
    logic [31:0] q[$], exp[$];
    int unsigned a0;
    q = '{2, 4, 6};
    exp = '{3, 2, 2, 6};
    for (int i = 0; i < 24; i++) begin q.push_back(32'hB000 + i); exp.push_back(32'hB000 + i); end
    load_src(0, q);
    load_src(64, '{3, 2, 2, 6});
    clear_dst();
    run_op(2'd1, 5);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reshape_err: got %0b want 0", err); end
    n_tests++; if (elem !== 32'd24) begin n_fail++; $display("FAIL reshape_elem: got %0d want 24", elem); end
    foreach (exp[i]) begin
      n_tests++;
      if (dst_mem[8'(128 + i)] !== exp[i]) begin
        n_fail++; $display("FAIL reshape_word%0d: got %h want %h", i, dst_mem[8'(128 + i)], exp[i]); end
    end
    finish_op();
    load_src(64, '{2, 5, 5});
    clear_dst();
    a0 = acc[2'd2];
    run_op(2'd1, 0);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL reshape_mismatch_err: got %0b want 1", err); end
    n_tests++; if (acc[2'd2] !== a0 || dst_mem[8'd128] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL reshape_mismatch_nowrite: writes=%0d want 0", acc[2'd2] - a0); end
    finish_op();
  endtask

  task automatic test_copy_zero();
    int unsigned a_s = acc[2'd0];
    int unsigned a_d = acc[2'd2];
    load_src(0, '{1, 0, 32'h1234_5678});
    clear_dst();
    run_op(2'd2, 0);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %0b want 0", err); end
    n_tests++; if (elem !== 32'd0) begin n_fail++; $display("FAIL zero_elem: got %0d want 0", elem); end
    n_tests++; if (dst_mem[8'd128] !== 32'd1 || dst_mem[8'd129] !== 32'd0) begin
      n_fail++; $display("FAIL zero_header: got %h %h want 1 0", dst_mem[8'd128], dst_mem[8'd129]); end
    n_tests++; if (acc[2'd0] - a_s !== 2 || acc[2'd2] - a_d !== 2) begin
      n_fail++; $display("FAIL zero_traffic: reads=%0d writes=%0d want 2 2", acc[2'd0] - a_s, acc[2'd2] - a_d); end
    finish_op();
  endtask

  task automatic test_bad_header();
    int unsigned a_s, a_h, a_d;
    logic [31:0] q[$];
    q = '{5, 1, 1, 1, 1, 1};
    load_src(0, q);
    a_d = acc[2'd2];
    run_op(2'd2, 0);
    n_tests++; if (err !== 1'b1 || acc[2'd2] !== a_d) begin
      n_fail++; $display("FAIL ndims_max_plus1: err=%0b writes=%0d want 1 0", err, acc[2'd2] - a_d); end
    finish_op();
    load_src(0, '{0});
    run_op(2'd0, 0);
    n_tests++; if (err !== 1'b1 || elem !== 32'd0) begin
      n_fail++; $display("FAIL ndims_zero: err=%0b elem=%0d want 1 0", err, elem); end
    finish_op();
    load_src(0, '{2, 32'h0001_0000, 32'h0001_0000});
    a_d = acc[2'd2];
    run_op(2'd0, 0);
    n_tests++; if (err !== 1'b1 || acc[2'd2] !== a_d) begin
      n_fail++; $display("FAIL overflow: err=%0b writes=%0d want 1 0", err, acc[2'd2] - a_d); end
    finish_op();
    a_s = acc[2'd0]; a_h = acc[2'd1]; a_d = acc[2'd2];
    run_op(2'd3, 0);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL mode3_err: got %0b want 1", err); end
    n_tests++; if (acc[2'd0] !== a_s || acc[2'd1] !== a_h || acc[2'd2] !== a_d) begin
      n_fail++; $display("FAIL mode3_traffic: got %0d accesses want 0",
                          (acc[2'd0] - a_s) + (acc[2'd1] - a_h) + (acc[2'd2] - a_d)); end
    finish_op();
  endtask

  task automatic test_stalls();
    logic [31:0] q[$];
    int v0 = viol;
    q = '{3, 2, 2, 3};
    for (int i = 0; i < 12; i++) q.push_back(32'hC000 + i * 7);
    load_src(0, q);
    clear_dst();
    stall_en = 1'b1;
    run_op(2'd2, 0);
    stall_en = 1'b0;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL stall_err: got %0b want 0", err); end
    foreach (q[i]) begin
      n_tests++;
      if (dst_mem[8'(128 + i)] !== q[i]) begin
        n_fail++; $display("FAIL stall_word%0d: got %h want %h", i, dst_mem[8'(128 + i)], q[i]); end
    end
    n_tests++; if (viol !== v0) begin n_fail++; $display("FAIL stall_protocol: got %0d want 0", viol - v0); end
    finish_op();
  endtask

  task automatic test_reset_mid();
    logic [31:0] q[$], exp[$];
    int unsigned a0 = acc[2'd2];
    int t = 0;
    q = '{1, 40};
    for (int i = 0; i < 40; i++) q.push_back(32'hD000 + i);
    load_src(0, q);
    mode = 2'd2;
    go = 1'b1;
    while (acc[2'd2] - a0 < 12 && t < 2000) begin @(negedge clk); t++; end
    n_tests++; if (acc[2'd2] - a0 < 12) begin
      n_fail++; $display("FAIL midreset_reach: writes=%0d want 12", acc[2'd2] - a0); end
    rst_l = 1'b0;
    #1;
    n_tests++; if (done !== 1'b0 || err !== 1'b0 || elem !== 32'd0) begin
      n_fail++; $display("FAIL midreset_outputs: done=%0b err=%0b elem=%0d want 0 0 0", done, err, elem); end
    n_tests++;
    if ({src_if.r_en, src_if.avail, shp_if.r_en, dst_if.w_en, dst_if.avail} !== 5'b0) begin
      n_fail++; $display("FAIL midreset_handles: src_ren=%0b dst_wen=%0b want 0 0", src_if.r_en, dst_if.w_en); end
    go = 1'b0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);
    q = '{2, 3, 3};
    exp = '{1, 9};
    for (int i = 0; i < 9; i++) begin q.push_back(32'hE000 + i); exp.push_back(32'hE000 + i); end
    load_src(0, q);
    clear_dst();
    run_op(2'd0, 0);
    n_tests++; if (err !== 1'b0 || elem !== 32'd9) begin
      n_fail++; $display("FAIL postreset_status: err=%0b elem=%0d want 0 9", err, elem); end
    foreach (exp[i]) begin
      n_tests++;
      if (dst_mem[8'(128 + i)] !== exp[i]) begin
        n_fail++; $display("FAIL postreset_word%0d: got %h want %h", i, dst_mem[8'(128 + i)], exp[i]); end
    end
    finish_op();
  endtask

  task automatic test_hold_go();
    int unsigned a_sum;
    int bad = 0;
    load_src(0, '{1, 2, 32'hF000, 32'hF001});
    run_op(2'd2, 0);
    a_sum = acc[2'd0] + acc[2'd1] + acc[2'd2];
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b1) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL hold_done: dropped %0d cycles want 0", bad); end
    n_tests++; if (acc[2'd0] + acc[2'd1] + acc[2'd2] !== a_sum) begin
      n_fail++; $display("FAIL hold_traffic: got %0d accesses want 0",
                          acc[2'd0] + acc[2'd1] + acc[2'd2] - a_sum); end
    go = 1'b0;
    @(negedge clk);
    n_tests++; if (done !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: done=%0b err=%0b want 0 0", done, err); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_flatten();
    test_reshape();
    test_copy_zero();
    test_bad_header();
    test_stalls();
    test_reset_mid();
    test_hold_go();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
